// File: rtl/div_pkg.sv
// Shared types and constants for the divider operand sequencer.
package div_pkg;

  localparam int DVD_W       = 10;
  localparam int DVS_W       = 5;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_DVD,
    S_DVS,
    S_WAIT,
    S_RESP
  } div_seq_state_t;

endpackage

// File: rtl/div_op_sequencer_if.sv
// Request/response handshakes plus the Divider's shared-bus pins.
interface div_op_sequencer_if;
  import div_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [DVD_W-1:0] req_dividend;
  logic [DVS_W-1:0] req_divisor;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DVS_W-1:0] rsp_quotient;
  logic [DVS_W-1:0] rsp_remainder;
  logic             rsp_divby0;
  logic             rsp_ov;
  logic             rsp_timeout;

  logic             div_rst;
  logic             div_start;
  logic [DVD_W-1:0] div_data_in;
  logic [DVS_W-1:0] div_data_out;
  logic             div_doneq;
  logic             div_donew;
  logic             div_divby0;
  logic             div_ov;

  // slave is the sequencer; master is the request producer plus the divider
  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
           div_data_out, div_doneq, div_donew, div_divby0, div_ov,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder,
           rsp_divby0, rsp_ov, rsp_timeout, div_rst, div_start, div_data_in
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
           div_data_out, div_doneq, div_donew, div_divby0, div_ov,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder,
           rsp_divby0, rsp_ov, rsp_timeout, div_rst, div_start, div_data_in
  );

endinterface

// File: rtl/div_wait_timer.sv
// Clearable up-counter that saturates at TIMEOUT and flags terminal count.
module div_wait_timer #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TW'(TIMEOUT));

endmodule

// File: rtl/div_op_sequencer.sv
// Drives one division through the serial Divider and collects the result
// into a single registered response word.
module div_op_sequencer
  import div_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = 7
) (
  input logic               clk,
  input logic               rst,
  div_op_sequencer_if.slave bus
);

  div_seq_state_t   state, state_n;
  logic [DVD_W-1:0] dvd_q, dvd_n;
  logic [DVS_W-1:0] dvs_q, dvs_n;
  logic             q_cap, q_cap_n, r_cap, r_cap_n;
  logic [DVS_W-1:0] quot_n, rem_n;
  logic             divby0_n, ov_n, timeout_n;
  logic [DVD_W-1:0] data_in_n;
  logic             accept, tc;

  assign accept = (state == S_IDLE) && bus.req_valid && bus.req_ready;

  div_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (state == S_WAIT),
    .tc (tc)
  );

  always_comb begin
    state_n   = state;
    dvd_n     = dvd_q;
    dvs_n     = dvs_q;
    q_cap_n   = q_cap;
    r_cap_n   = r_cap;
    quot_n    = bus.rsp_quotient;
    rem_n     = bus.rsp_remainder;
    divby0_n  = bus.rsp_divby0;
    ov_n      = bus.rsp_ov;
    timeout_n = bus.rsp_timeout;
    data_in_n = bus.div_data_in;

    case (state)
      S_IDLE: begin
        if (accept) begin
          dvd_n     = bus.req_dividend;
          dvs_n     = bus.req_divisor;
          q_cap_n   = 1'b0;
          r_cap_n   = 1'b0;
          quot_n    = '0;
          rem_n     = '0;
          divby0_n  = 1'b0;
          ov_n      = 1'b0;
          timeout_n = 1'b0;
          state_n   = S_CLR;
        end
      end
      S_CLR:   state_n = S_START;
      S_START: state_n = S_DVD;
      S_DVD:   state_n = S_DVS;
      S_DVS:   state_n = S_WAIT;
      S_WAIT: begin
        // doneq has precedence; a simultaneous donew is left for a later cycle
        if (bus.div_doneq && !q_cap) begin
          quot_n  = bus.div_data_out;
          q_cap_n = 1'b1;
        end else if (bus.div_donew && !r_cap) begin
          rem_n   = bus.div_data_out;
          r_cap_n = 1'b1;
        end
        if (bus.div_divby0 || bus.div_ov) begin
          divby0_n = bus.div_divby0;
          ov_n     = bus.div_ov;
          state_n  = S_RESP;
        end else if (q_cap_n && r_cap_n) begin
          state_n = S_RESP;
        end else if (tc) begin
          timeout_n = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_IDLE, S_CLR, S_START: data_in_n = '0;
      S_DVD:                  data_in_n = dvd_q;
      S_DVS:                  data_in_n = {{(DVD_W-DVS_W){1'b0}}, dvs_q};
      default:                data_in_n = bus.div_data_in;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      dvd_q             <= '0;
      dvs_q             <= '0;
      q_cap             <= 1'b0;
      r_cap             <= 1'b0;
      bus.req_ready     <= 1'b0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_quotient  <= '0;
      bus.rsp_remainder <= '0;
      bus.rsp_divby0    <= 1'b0;
      bus.rsp_ov        <= 1'b0;
      bus.rsp_timeout   <= 1'b0;
      bus.div_rst       <= 1'b1;
      bus.div_start     <= 1'b0;
      bus.div_data_in   <= '0;
    end else begin
      state             <= state_n;
      dvd_q             <= dvd_n;
      dvs_q             <= dvs_n;
      q_cap             <= q_cap_n;
      r_cap             <= r_cap_n;
      bus.req_ready     <= (state_n == S_IDLE);
      bus.rsp_valid     <= (state_n == S_RESP);
      bus.rsp_quotient  <= quot_n;
      bus.rsp_remainder <= rem_n;
      bus.rsp_divby0    <= divby0_n;
      bus.rsp_ov        <= ov_n;
      bus.rsp_timeout   <= timeout_n;
      bus.div_rst       <= (state_n == S_CLR);
      bus.div_start     <= (state_n == S_START);
      bus.div_data_in   <= data_in_n;
    end
  end

endmodule
